bg_fill_engine: RTL and testbench

BG_FILL_ENGINE -- requirements
Module: bg_fill_engine

---
 rtl/bg_fill_engine_pkg.sv | 19 +
 rtl/bg_fill_engine_sync2.sv | 29 ++
 rtl/bg_fill_engine.sv | 160 ++++++++++++++++
 tb/tb_bg_fill_engine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bg_fill_engine_pkg.sv
// Shared display package: frame-buffer geometry defaults and the fill-engine
// FSM state type.
package bg_fill_engine_pkg;

  localparam int unsigned BG_WORDS  = 786432;
  localparam int unsigned BG_ADDR_W = 22;
  localparam int unsigned BG_DATA_W = 32;

  localparam logic [BG_ADDR_W-1:0] BG_BASE0 = 22'h000000;
  localparam logic [BG_ADDR_W-1:0] BG_BASE1 = 22'h100000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_DONE_HI = 2'd2,
    ST_DONE_LO = 2'd3
  } bg_state_t;

endpackage

// File: rtl/bg_fill_engine_sync2.sv
// sync2: two-flop level synchronizer for cross-domain handshake signals.
// Ports:
//   clock - destination-domain clock
//   reset - synchronous active-high reset, clears both flops
//   d     - asynchronous level input
//   q     - synchronized level output
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/bg_fill_engine.sv
// bg_fill_engine: fills one frame buffer with a constant colour.
// A start request (level, held until start_ack) latches fb_sel and color,
// then WORDS consecutive writes are issued over a valid/ready write port.
// Completion is signalled with a 4-phase done/done_ack handshake.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   start / start_ack   - fill request level / one-cycle acceptance pulse
//   done / done_ack     - completion level / asynchronous echo
//   fb_sel, color       - target buffer and fill value, sampled at acceptance
//   wr_valid, wr_ready  - write handshake
//   wr_addr, wr_data    - write word address and data
// All outputs are registered.
module bg_fill_engine
  import bg_fill_engine_pkg::*;
#(
  parameter int unsigned       WORDS  = BG_WORDS,
  parameter int unsigned       ADDR_W = BG_ADDR_W,
  parameter int unsigned       DATA_W = BG_DATA_W,
  parameter logic [ADDR_W-1:0] BASE0  = BG_BASE0,
  parameter logic [ADDR_W-1:0] BASE1  = BG_BASE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              start_ack,
  output logic              done,
  input  logic              done_ack,
  input  logic              fb_sel,
  input  logic [DATA_W-1:0] color,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int unsigned CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  bg_state_t r_state, w_state_nxt;

  logic              r_start_ack, w_start_ack;
  logic              r_done,      w_done;
  logic              r_wr_valid,  w_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr,   w_wr_addr;
  logic [DATA_W-1:0] r_wr_data,   w_wr_data;
  logic [CNT_W-1:0]  r_count,     w_count;
  logic              r_sel,       w_sel;
  logic [DATA_W-1:0] r_color,     w_color;

  logic              w_done_ack_s;
  logic [ADDR_W-1:0] w_base;
  logic [CNT_W-1:0]  w_count_inc;
  logic              w_accept;

  sync2 u_done_ack_sync (
    .clock (clock),
    .reset (reset),
    .d     (done_ack),
    .q     (w_done_ack_s)
  );

  assign w_base      = r_sel ? BASE1 : BASE0;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_accept    = r_wr_valid & wr_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (start)                                w_state_nxt = ST_FILL;
      ST_FILL:    if (w_accept && (r_count == LAST))        w_state_nxt = ST_DONE_HI;
      ST_DONE_HI: if (w_done_ack_s)                         w_state_nxt = ST_DONE_LO;
      ST_DONE_LO: if (!w_done_ack_s)                        w_state_nxt = ST_IDLE;
      default:                                              w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath. The first FILL
  // cycle (wr_valid still low) only loads the first address, which keeps
  // start_ack and the first wr_valid one cycle apart.
  always_comb begin
    w_start_ack = 1'b0;
    w_done      = r_done;
    w_wr_valid  = r_wr_valid;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_count     = r_count;
    w_sel       = r_sel;
    w_color     = r_color;
    unique case (r_state)
      ST_IDLE: begin
        w_done     = 1'b0;
        w_wr_valid = 1'b0;
        if (start) begin
          w_start_ack = 1'b1;
          w_sel       = fb_sel;
          w_color     = color;
          w_count     = '0;
        end
      end
      ST_FILL: begin
        if (!r_wr_valid) begin
          w_wr_valid = 1'b1;
          w_wr_addr  = w_base + ADDR_W'(r_count);
          w_wr_data  = r_color;
        end else if (wr_ready) begin
          w_count = w_count_inc;
          if (r_count == LAST) begin
            w_wr_valid = 1'b0;
            w_done     = 1'b1;
          end else begin
            w_wr_addr = w_base + ADDR_W'(w_count_inc);
          end
        end
      end
      ST_DONE_HI: if (w_done_ack_s) w_done = 1'b0;
      ST_DONE_LO: w_done = 1'b0;
      default: begin
        w_done     = 1'b0;
        w_wr_valid = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_start_ack <= 1'b0;
      r_done      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_count     <= '0;
      r_sel       <= 1'b0;
      r_color     <= '0;
    end else begin
      r_start_ack <= w_start_ack;
      r_done      <= w_done;
      r_wr_valid  <= w_wr_valid;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
      r_count     <= w_count;
      r_sel       <= w_sel;
      r_color     <= w_color;
    end
  end

  assign start_ack = r_start_ack;
  assign done      = r_done;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_bg_fill_engine.sv
// Directed-plus-random bench for bg_fill_engine with WORDS=4.
module tb_bg_fill_engine;

  localparam int unsigned WORDS  = 4;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] BASE0 = 22'h000000;
  localparam logic [ADDR_W-1:0] BASE1 = 22'h100000;
  localparam int unsigned BUDGET = 200;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              start_ack;
  logic              done;
  logic              done_ack = 1'b0;
  logic              fb_sel = 1'b0;
  logic [DATA_W-1:0] color = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clock = ~clock;

  bg_fill_engine #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BASE0  (BASE0),
    .BASE1  (BASE1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .start_ack (start_ack),
    .done      (done),
    .done_ack  (done_ack),
    .fb_sel    (fb_sel),
    .color     (color),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One fill. Model: the k-th accepted write goes to base+k with the colour
  // latched at acceptance; ready mode 0 = always high, 1 = 1,0,1,0..., 2 = random.
  task automatic run_fill(input logic sel, input logic [DATA_W-1:0] col,
                          input int unsigned mode, input bit acked);
    int unsigned acc = 0;
    int unsigned cyc = 0;
    int unsigned tog = 0;
    logic [ADDR_W-1:0] base;
    logic rdy;
    base = sel ? BASE1 : BASE0;
    if (!acked) begin
      fb_sel = sel;
      color  = col;
      start  = 1'b1;
      tick(); cyc++;
      check("start_ack", start_ack, 1);
      start = 1'b0;
    end
    // Inputs changing after acceptance must not affect the fill.
    fb_sel = ~sel;
    color  = $urandom;
    tick(); cyc++;
    check("ack_pulse", start_ack, 0);
    while (acc < WORDS && cyc < BUDGET) begin
      check("wr_valid", wr_valid, 1);
      check("wr_addr", wr_addr, ADDR_W'(base + acc));
      check("wr_data", wr_data, col);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (tog % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tog++;
      wr_ready = rdy;
      tick(); cyc++;
      if (rdy) acc++;
    end
    wr_ready = 1'b0;
    check("writes", acc, WORDS);
    check("valid_drop", wr_valid, 0);
    check("done_rise", done, 1);
    if (!acked && mode == 0) check("latency", cyc, WORDS + 2);
  endtask

  // 4-phase done handshake; optionally holds start high the whole time and
  // expects exactly one start_ack after the FSM is back in IDLE.
  task automatic done_handshake(input bit hold_start, input logic sel,
                                input logic [DATA_W-1:0] col);
    int unsigned hi = 0;
    int unsigned acks = 0;
    if (hold_start) begin
      fb_sel = sel;
      color  = col;
      start  = 1'b1;
    end
    done_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) hi++;
      if (start_ack !== 1'b0) acks++;
    end
    check("done_hold", hi, 20);
    done_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (start_ack !== 1'b0) acks++;
      check("done_fall", done, (i < 2) ? 1 : 0);
    end
    done_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (start_ack !== 1'b0) acks++;
    end
    check("early_ack", acks, 0);
    tick();
    check("ack_after_lo", start_ack, hold_start ? 1 : 0);
    if (hold_start) start = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] c;
    logic s;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_start_ack", start_ack, 0);
    check("rst_done", done, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    // Basic fill to buffer 0, ready high.
    run_fill(1'b0, 32'hAABBCCDD, 0, 1'b0);
    // Start held through the handshake; next fill to buffer 1 with stalls.
    c = $urandom;
    done_handshake(1'b1, 1'b1, c);
    run_fill(1'b1, c, 1, 1'b1);
    done_handshake(1'b0, 1'b0, '0);

    // Reset after two accepted writes.
    fb_sel = 1'b1;
    color  = 32'h12345678;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr_ready = 1'b1;
    tick();
    tick();
    wr_ready = 1'b0;
    reset    = 1'b1;
    tick();
    check("rst_mid_valid", wr_valid, 0);
    check("rst_mid_addr", wr_addr, 0);
    reset = 1'b0;
    begin
      int unsigned bad = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done !== 1'b0 || wr_valid !== 1'b0) bad++;
      end
      check("rst_mid_quiet", bad, 0);
    end
    run_fill(1'b0, 32'h0BADF00D, 0, 1'b0);
    done_handshake(1'b0, 1'b0, '0);

    // Random fills with random back-pressure.
    for (int n = 0; n < 4; n++) begin
      s = 1'($urandom_range(0, 1));
      c = $urandom;
      run_fill(s, c, 2, 1'b0);
      done_handshake(1'b0, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
